// File: rtl/thresh_fifo.sv
// -----------------------------------------------------------------------------
// thresh_fifo
//
// Synchronous show-ahead FIFO with registered occupancy flags and
// programmable almost-full / almost-empty thresholds.
//
// Parameters
//   FIFO_DEPTH    : number of entries (power of two, >= 2)
//   FIFO_WIDTH    : data word width in bits
//   AFULL_THRESH  : almost_full asserts when occupancy >= this value
//   AEMPTY_THRESH : almost_empty asserts when occupancy <= this value
//
// Ports
//   clk          : single clock, all state updates on its rising edge
//   rst          : synchronous active-high reset
//   data_in      : write data
//   write_en     : push request
//   data_out     : oldest stored word (combinational read, valid when !empty)
//   next_en      : pop request
//   count        : current occupancy
//   empty, full, almost_empty, almost_full : registered status flags
//   overflow     : sticky flag, set by a dropped push
//   underflow    : sticky flag, set by a pop request while empty
//   clr_err      : clears both sticky flags (a same-cycle set wins)
//
// Build option
//   THRESH_FIFO_ERR_FLAGS_EN : when defined, overflow/underflow are real
//   sticky registers; when undefined they are tied to 0 and clr_err is
//   ignored.
// -----------------------------------------------------------------------------
module thresh_fifo #(
  parameter int FIFO_DEPTH    = 32,
  parameter int FIFO_WIDTH    = 8,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [FIFO_WIDTH-1:0]             data_in,
  input  logic                              write_en,
  output logic [FIFO_WIDTH-1:0]             data_out,
  input  logic                              next_en,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              empty,
  output logic                              full,
  output logic                              almost_empty,
  output logic                              almost_full,
  output logic                              overflow,
  output logic                              underflow,
  input  logic                              clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  // Storage is never reset; reset only moves the pointers, which makes
  // any previously pushed words unreachable.
  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          empty_reg;
  logic          full_reg;
  logic          almost_empty_reg;
  logic          almost_full_reg;

  logic          push;
  logic          pop;

  // A pop frees a slot on the same edge, so a push into a full FIFO is
  // accepted when paired with an accepted pop.
  always_comb begin
    pop        = next_en && !empty_reg;
    push       = write_en && (!full_reg || pop);
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  // Flags are computed from the next-state count so they change on the
  // same edge as count rather than one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      empty_reg        <= 1'b1;
      full_reg         <= 1'b0;
      almost_empty_reg <= 1'b1;
      almost_full_reg  <= 1'b0;
    end else begin
      empty_reg        <= (count_next == '0);
      full_reg         <= (count_next == DEPTH_C);
      almost_empty_reg <= (count_next <= AEMPTY_C);
      almost_full_reg  <= (count_next >= AFULL_C);
    end
  end

  assign data_out     = mem[rd_ptr_reg];
  assign count        = count_reg;
  assign empty        = empty_reg;
  assign full         = full_reg;
  assign almost_empty = almost_empty_reg;
  assign almost_full  = almost_full_reg;

`ifdef THRESH_FIFO_ERR_FLAGS_EN
  logic overflow_reg;
  logic underflow_reg;
  logic push_dropped;
  logic pop_ignored;

  assign push_dropped = write_en && full_reg && !pop;
  assign pop_ignored  = next_en && empty_reg;

  // Set has priority over a same-cycle clear so no error event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (push_dropped) begin
        overflow_reg <= 1'b1;
      end else if (clr_err) begin
        overflow_reg <= 1'b0;
      end
      if (pop_ignored) begin
        underflow_reg <= 1'b1;
      end else if (clr_err) begin
        underflow_reg <= 1'b0;
      end
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: doc/thresh_fifo.md
THRESH_FIFO -- requirements
Module: thresh_fifo

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 32, number of entries (power of two, >= 2).
REQ-002 The module SHALL have parameter FIFO_WIDTH, default 8, data word width in bits.
REQ-003 The module SHALL have parameter AFULL_THRESH, default FIFO_DEPTH-2, occupancy at or above which almost_full asserts (1..FIFO_DEPTH).
REQ-004 The module SHALL have parameter AEMPTY_THRESH, default 2, occupancy at or below which almost_empty asserts (0..FIFO_DEPTH-1).
REQ-005 The module SHALL have the following ports: clk, rst, data_in, write_en, data_out, next_en, count, empty, full, almost_empty, almost_full, overflow, underflow and clr_err.
REQ-006 Port clk SHALL be input, 1 bit, the single clock, with all state updating on its rising edge.
REQ-007 Port rst SHALL be input, 1 bit, a synchronous active-high reset.
REQ-008 Port data_in SHALL be input, FIFO_WIDTH bits, the write data.
REQ-009 Port write_en SHALL be input, 1 bit, a push request.
REQ-010 Port data_out SHALL be output, FIFO_WIDTH bits, the oldest stored word (show-ahead).
REQ-011 Port next_en SHALL be input, 1 bit, a pop request.
REQ-012 Port count SHALL be output, $clog2(FIFO_DEPTH+1) bits, the current occupancy.
REQ-013 Ports empty, full, almost_empty and almost_full SHALL each be output, 1 bit, registered status flags.
REQ-014 Ports overflow and underflow SHALL each be output, 1 bit, sticky error flags.
REQ-015 Port clr_err SHALL be input, 1 bit, and clear both sticky error flags.

Function
REQ-016 A push SHALL be accepted when write_en=1 and (full=0 or an accepted pop occurs in the same cycle); the word is stored at the write pointer on that edge.
REQ-017 A pop SHALL be accepted when next_en=1 and empty=0; the read pointer advances on that edge.
REQ-018 A write_en with full=1 and no accepted pop SHALL be dropped, leaving storage, pointers and count unchanged.
REQ-019 A next_en with empty=1 SHALL be ignored; a simultaneous write_en is still accepted, making count 1 next cycle.
REQ-020 Pointers SHALL wrap from FIFO_DEPTH-1 to 0.
REQ-021 count SHALL increment on push only, decrement on pop only, and stay unchanged on push+pop or neither.
REQ-022 data_out SHALL be a combinational read of storage at the read pointer, valid whenever empty=0, so the first word appears the cycle after its push; its value while empty=1 is don't-care.
REQ-023 empty, full, almost_empty and almost_full SHALL be registered from next-state count: count==0, count==FIFO_DEPTH, count<=AEMPTY_THRESH and count>=AFULL_THRESH respectively, and SHALL update on the same edge as count.
REQ-024 A push+pop in the same cycle with count==1 SHALL keep empty=0, and data_out SHALL show the newly pushed word next cycle.
REQ-025 Occupancy SHALL be derived from count, not from pointer equality, so full and empty never assert together.

Reset
REQ-026 On rst=1 at a clock edge, pointers and count SHALL reset to 0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0 and underflow=0, with storage contents left unchanged.
REQ-027 rst SHALL take priority over write_en, next_en and clr_err in the same cycle, and contents pushed before reset SHALL be unreachable afterwards.

Configuration
REQ-028 With macro THRESH_FIFO_ERR_FLAGS_EN defined, overflow SHALL set on a dropped push, underflow SHALL set on an ignored pop, and both SHALL hold until clr_err=1 or rst, with set winning over a same-cycle clr_err.
REQ-029 With THRESH_FIFO_ERR_FLAGS_EN undefined, overflow and underflow SHALL be tied to 0 with no error registers, and clr_err SHALL be ignored.

Verification (FIFO_DEPTH=4, FIFO_WIDTH=8, AFULL_THRESH=3, AEMPTY_THRESH=1, macro defined)
REQ-030 The bench SHALL cover: after rst, push 0xA1 -> next cycle count=1, empty=0, almost_empty=1, data_out=0xA1.
REQ-031 The bench SHALL cover: push 0x01..0x04 -> count=3 gives almost_full=1; count=4 gives full=1; a fifth push of 0x05 is dropped with overflow=1; pops return 0x01..0x04 in order, ending with empty=1.
REQ-032 The bench SHALL cover: when full, push 0x55 with a same-cycle pop -> count stays 4 and 0x55 is read last.
REQ-033 The bench SHALL cover: when empty, next_en=1 -> underflow=1 and count=0; clr_err=1 then clears both flags the next cycle.
REQ-034 The bench SHALL cover: 10 push/pop pairs through pointer wrap -> data order preserved and count stays 1.
REQ-035 The bench SHALL cover: rst asserted at count=3 with a same-cycle push -> count=0, empty=1, flags cleared.
